// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - frame timing constants and slot/bit index helpers for the AK4619 TDM engine
package tdm_pkg;

   localparam int FRAME_CYCLES = 256;
   localparam int FCNT_W       = 8;

   // A frame must be exactly one fs period of the 256fs clock and every sample must fit its slot.
   function automatic bit cfg_legal(input int w, input int slots, input int slot_bits,
                                    input int bclk_div);
      return (w >= 1) && (w <= slot_bits) && (bclk_div >= 2) && ((bclk_div % 2) == 0)
          && ((slots * slot_bits * bclk_div) == FRAME_CYCLES);
   endfunction

   function automatic logic [FCNT_W-1:0] fcnt_phase(input logic [FCNT_W-1:0] fcnt,
                                                     input int div_log2);
      return fcnt & ~({FCNT_W{1'b1}} << div_log2);
   endfunction

   function automatic logic [FCNT_W-1:0] bit_index(input logic [FCNT_W-1:0] fcnt,
                                                    input int div_log2);
      return fcnt >> div_log2;
   endfunction

   function automatic logic [FCNT_W-1:0] slot_of(input logic [FCNT_W-1:0] bidx,
                                                  input int sb_log2);
      return bidx >> sb_log2;
   endfunction

   function automatic logic [FCNT_W-1:0] bit_in_slot(input logic [FCNT_W-1:0] bidx,
                                                      input int sb_log2);
      return bidx & ~({FCNT_W{1'b1}} << sb_log2);
   endfunction

endpackage

// File: rtl/tdm_slot_ser.sv
// rtl/tdm_slot_ser.sv - frame-wide DAC shift register, samples left-aligned in zero-padded slots
module tdm_slot_ser
   import tdm_pkg::*;
#(
   parameter int W         = 16,
   parameter int SLOTS     = 4,
   parameter int SLOT_BITS = 32
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_load,
   input  logic [SLOTS*W-1:0]   i_frame,
   input  logic                 i_shift,
   output logic                 o_bit
);

   localparam int FRAME_BITS = SLOTS * SLOT_BITS;

   logic [FRAME_BITS-1:0] r_sr;
   logic [FRAME_BITS-1:0] w_pad;

   // Slot 0 goes out first, so it occupies the top of the register.
   always_comb begin
      w_pad = '0;
      for (int s = 0; s < SLOTS; s++) begin
         w_pad[FRAME_BITS-1-s*SLOT_BITS -: W] = i_frame[s*W +: W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sr <= '0;
      end else if (i_load) begin
         r_sr <= w_pad;
      end else if (i_shift) begin
         r_sr <= {r_sr[FRAME_BITS-2:0], 1'b0};
      end
   end

   assign o_bit = r_sr[FRAME_BITS-1];

endmodule

// File: rtl/ak4619_tdm_engine.sv
// rtl/ak4619_tdm_engine.sv - AK4619 TDM engine: BICK/LRCK generation, DAC serialiser, ADC deserialiser
module ak4619_tdm_engine
   import tdm_pkg::*;
#(
   parameter int W           = 16,
   parameter int SLOTS       = 4,
   parameter int SLOT_BITS   = 32,
   parameter int BCLK_DIV    = 2,
   parameter int MUTE_FRAMES = 4
)(
   input  logic                 clk_256fs,
   input  logic                 rst_n,
   output logic                 o_bick,
   output logic                 o_lrck,
   output logic                 o_sdin,
   input  logic                 i_sdout,
   input  logic [SLOTS*W-1:0]   i_dac,
   input  logic                 i_dac_valid,
   output logic                 o_dac_ready,
   output logic [SLOTS*W-1:0]   o_adc,
   output logic                 o_adc_valid,
   output logic                 o_frame_strobe,
   output logic                 o_underrun
);

   localparam int DIV_LOG2 = $clog2(BCLK_DIV);
   localparam int SB_LOG2  = $clog2(SLOT_BITS);
   localparam int CAP_W    = SLOTS * W;
   localparam int CAP_IW   = (CAP_W < 2) ? 1 : $clog2(CAP_W);
   localparam int MUTE_W   = (MUTE_FRAMES < 1) ? 1 : $clog2(MUTE_FRAMES + 1);

   if (!cfg_legal(W, SLOTS, SLOT_BITS, BCLK_DIV)) begin : g_illegal_cfg
      $error("ak4619_tdm_engine: W/SLOTS/SLOT_BITS/BCLK_DIV do not form a legal 256fs frame");
   end

   logic [FCNT_W-1:0] r_fcnt;
   logic [MUTE_W-1:0] r_mute_cnt;
   logic [CAP_W-1:0]  r_hold;
   logic              r_hold_full;
   logic [CAP_W-1:0]  r_cap;
   logic              r_bick;
   logic              r_lrck;
   logic              r_sdin;
   logic [CAP_W-1:0]  r_adc;
   logic              r_adc_valid;
   logic              r_frame_strobe;
   logic              r_underrun;

   logic [FCNT_W-1:0] w_phase;
   logic [FCNT_W-1:0] w_bidx;
   logic [FCNT_W-1:0] w_slot;
   logic [FCNT_W-1:0] w_sbit;
   logic              w_fall;
   logic              w_sample;
   logic              w_frame_end;
   logic              w_muted;
   logic              w_xfer;
   logic              w_ser_bit;
   logic [CAP_W-1:0]  w_load_frame;
   logic [CAP_W-1:0]  w_cap_next;
   logic [CAP_IW-1:0] w_cap_idx;

   assign w_phase     = fcnt_phase(r_fcnt, DIV_LOG2);
   assign w_bidx      = bit_index(r_fcnt, DIV_LOG2);
   assign w_slot      = slot_of(w_bidx, SB_LOG2);
   assign w_sbit      = bit_in_slot(w_bidx, SB_LOG2);
   assign w_fall      = (w_phase == '0);
   assign w_sample    = (w_phase == FCNT_W'(BCLK_DIV / 2));
   assign w_frame_end = (r_fcnt == FCNT_W'(FRAME_CYCLES - 1));
   assign w_muted     = (r_mute_cnt != '0);
   assign w_xfer      = i_dac_valid & ~r_hold_full;

   // An empty holding register at the frame boundary sends a silent frame.
   assign w_load_frame = r_hold_full ? r_hold : '0;

   tdm_slot_ser #(
      .W         (W),
      .SLOTS     (SLOTS),
      .SLOT_BITS (SLOT_BITS)
   ) u_ser (
      .clk     (clk_256fs),
      .rst_n   (rst_n),
      .i_load  (w_frame_end),
      .i_frame (w_load_frame),
      .i_shift (w_fall),
      .o_bit   (w_ser_bit)
   );

   // The last bit of the frame lands in the same cycle the frame is published, so publish the merged value.
   always_comb begin
      w_cap_next = r_cap;
      w_cap_idx  = CAP_IW'(int'(w_slot) * W + (W - 1) - int'(w_sbit));
      if (w_sample && (int'(w_sbit) < W)) begin
         w_cap_next[w_cap_idx] = i_sdout;
      end
   end

   always_ff @(posedge clk_256fs or negedge rst_n) begin
      if (!rst_n) begin
         r_fcnt         <= '0;
         r_mute_cnt     <= MUTE_W'(MUTE_FRAMES);
         r_hold         <= '0;
         r_hold_full    <= 1'b0;
         r_cap          <= '0;
         r_bick         <= 1'b0;
         r_lrck         <= 1'b0;
         r_sdin         <= 1'b0;
         r_adc          <= '0;
         r_adc_valid    <= 1'b0;
         r_frame_strobe <= 1'b0;
         r_underrun     <= 1'b0;
      end else begin
         r_fcnt         <= r_fcnt + FCNT_W'(1);
         r_bick         <= (w_phase >= FCNT_W'(BCLK_DIV / 2));
         r_lrck         <= (r_fcnt < FCNT_W'(FRAME_CYCLES / 2));
         r_cap          <= w_cap_next;
         r_frame_strobe <= w_frame_end;
         r_adc_valid    <= w_frame_end & ~w_muted;
         r_underrun     <= w_frame_end & ~r_hold_full & ~w_muted;
         if (w_fall) begin
            r_sdin <= w_ser_bit & ~w_muted;
         end
         if (w_frame_end) begin
            if (w_muted) begin
               r_mute_cnt <= r_mute_cnt - MUTE_W'(1);
            end else begin
               r_adc <= w_cap_next;
            end
         end
         if (w_frame_end && r_hold_full) begin
            r_hold_full <= 1'b0;
         end else if (w_xfer) begin
            r_hold      <= i_dac;
            r_hold_full <= 1'b1;
         end
      end
   end

   assign o_bick         = r_bick;
   assign o_lrck         = r_lrck;
   assign o_sdin         = r_sdin;
   assign o_dac_ready    = ~r_hold_full;
   assign o_adc          = r_adc;
   assign o_adc_valid    = r_adc_valid;
   assign o_frame_strobe = r_frame_strobe;
   assign o_underrun     = r_underrun;

endmodule

// File: tb/tb_ak4619_tdm_engine.sv
// tb/tb_ak4619_tdm_engine.sv - self-checking bench for ak4619_tdm_engine with codec loopback
module tb_ak4619_tdm_engine;

   localparam int W           = 16;
   localparam int SLOTS       = 4;
   localparam int SLOT_BITS   = 32;
   localparam int BCLK_DIV    = 2;
   localparam int MUTE_FRAMES = 4;
   localparam int FW          = SLOTS * W;
   localparam int FRAME       = 256;
   localparam int NF_MAX      = 16;

   logic          clk_256fs = 1'b0;
   logic          rst_n = 1'b0;
   logic          o_bick, o_lrck, o_sdin;
   logic          i_sdout = 1'b0;
   logic [FW-1:0] i_dac = '0;
   logic          i_dac_valid = 1'b0;
   logic          o_dac_ready;
   logic [FW-1:0] o_adc;
   logic          o_adc_valid, o_frame_strobe, o_underrun;

   int errors = 0;
   int checks = 0;
   int n_valid, n_under;

   bit            p_en  [NF_MAX];
   int            p_pos [NF_MAX];
   logic [FW-1:0] p_dat [NF_MAX];
   logic [FW-1:0] tx    [NF_MAX];
   bit            und   [NF_MAX];

   ak4619_tdm_engine #(
      .W           (W),
      .SLOTS       (SLOTS),
      .SLOT_BITS   (SLOT_BITS),
      .BCLK_DIV    (BCLK_DIV),
      .MUTE_FRAMES (MUTE_FRAMES)
   ) dut (
      .clk_256fs      (clk_256fs),
      .rst_n          (rst_n),
      .o_bick         (o_bick),
      .o_lrck         (o_lrck),
      .o_sdin         (o_sdin),
      .i_sdout        (i_sdout),
      .i_dac          (i_dac),
      .i_dac_valid    (i_dac_valid),
      .o_dac_ready    (o_dac_ready),
      .o_adc          (o_adc),
      .o_adc_valid    (o_adc_valid),
      .o_frame_strobe (o_frame_strobe),
      .o_underrun     (o_underrun)
   );

   always #5 clk_256fs = ~clk_256fs;

   // A word accepted mid-frame plays in the next frame; one accepted on the boundary cycle plays a frame later.
   function automatic void build_expect(input int nf);
      for (int f = 0; f < nf; f++) begin
         tx[f]  = '0;
         und[f] = 1'b0;
      end
      for (int f = 1; f < nf; f++) begin
         if (p_en[f-1] && p_pos[f-1] < FRAME - 1)
            tx[f] = p_dat[f-1];
         else if (f >= 2 && p_en[f-2] && p_pos[f-2] == FRAME - 1)
            tx[f] = p_dat[f-2];
         else
            und[f] = 1'b1;
      end
   endfunction

   function automatic logic exp_sdin(input int k);
      int f, c, idx, s, b;
      if (k == 0) return 1'b0;
      f   = (k - 1) / FRAME;
      c   = (k - 1) % FRAME;
      idx = c / BCLK_DIV;
      s   = idx / SLOT_BITS;
      b   = idx % SLOT_BITS;
      if (f < MUTE_FRAMES || b >= W) return 1'b0;
      return tx[f][s*W + W - 1 - b];
   endfunction

   task automatic clear_plan;
      for (int f = 0; f < NF_MAX; f++) begin
         p_en[f]  = 1'b0;
         p_pos[f] = 0;
         p_dat[f] = FW'({$urandom, $urandom});
      end
   endtask

   task automatic apply_reset;
      rst_n       = 1'b0;
      i_dac_valid = 1'b0;
      i_sdout     = 1'b0;
      repeat (2) @(posedge clk_256fs);
      #1;
      rst_n = 1'b1;
   endtask

   // Drives the plan from reset release (k = edges since release) and checks every pin each cycle.
   task automatic run_plan(input int nf, input int stop_k);
      int f, c, push_k;
      logic e_bick, e_lrck, e_sdin, e_fs, e_av, e_ur, bnd;
      logic [FW-1:0] e_adc;
      build_expect(nf);
      push_k  = -10;
      n_valid = 0;
      n_under = 0;
      for (int k = 0; k < nf * FRAME && k != stop_k; k++) begin
         f = k / FRAME;
         c = k % FRAME;
         i_sdout = o_sdin;
         if (k == push_k + 1) begin
            checks++;
            if (o_dac_ready !== 1'b0) begin
               errors++;
               $display("FAIL ready_after_push k=%0d got=%b exp=0", k, o_dac_ready);
            end
         end
         if (p_en[f] && p_pos[f] == c) begin
            checks++;
            if (o_dac_ready !== 1'b1) begin
               errors++;
               $display("FAIL ready_at_push k=%0d got=%b exp=1", k, o_dac_ready);
            end
            i_dac       = p_dat[f];
            i_dac_valid = 1'b1;
            push_k      = k;
         end else begin
            i_dac       = FW'({$urandom, $urandom});
            i_dac_valid = 1'b0;
         end
         bnd    = (k > 0) && (c == 0);
         e_bick = (k > 0) && (((k - 1) % BCLK_DIV) >= BCLK_DIV / 2);
         e_lrck = (k > 0) && (((k - 1) % FRAME) < FRAME / 2);
         e_sdin = exp_sdin(k);
         e_fs   = bnd;
         e_av   = bnd && (f - 1 >= MUTE_FRAMES);
         e_ur   = e_av && und[f];
         e_adc  = (f - 1 >= MUTE_FRAMES) ? tx[f-1] : '0;
         checks += 7;
         if (o_bick !== e_bick) begin
            errors++; $display("FAIL bick k=%0d got=%b exp=%b", k, o_bick, e_bick);
         end
         if (o_lrck !== e_lrck) begin
            errors++; $display("FAIL lrck k=%0d got=%b exp=%b", k, o_lrck, e_lrck);
         end
         if (o_sdin !== e_sdin) begin
            errors++; $display("FAIL sdin k=%0d got=%b exp=%b", k, o_sdin, e_sdin);
         end
         if (o_frame_strobe !== e_fs) begin
            errors++; $display("FAIL frame_strobe k=%0d got=%b exp=%b", k, o_frame_strobe, e_fs);
         end
         if (o_adc_valid !== e_av) begin
            errors++; $display("FAIL adc_valid k=%0d got=%b exp=%b", k, o_adc_valid, e_av);
         end
         if (o_underrun !== e_ur) begin
            errors++; $display("FAIL underrun k=%0d got=%b exp=%b", k, o_underrun, e_ur);
         end
         if (o_adc !== e_adc) begin
            errors++; $display("FAIL adc k=%0d got=%h exp=%h", k, o_adc, e_adc);
         end
         if (o_adc_valid === 1'b1) n_valid++;
         if (o_underrun === 1'b1) n_under++;
         @(posedge clk_256fs);
         #1;
      end
      i_dac_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst_n       = 1'b0;
      i_dac_valid = 1'b0;
      i_dac       = '0;
      repeat (3) @(posedge clk_256fs);
      #1;
      checks += 3;
      if ({o_bick, o_lrck, o_sdin, o_adc_valid, o_frame_strobe, o_underrun} !== 6'b0) begin
         errors++;
         $display("FAIL reset_pins got=%b exp=000000",
                  {o_bick, o_lrck, o_sdin, o_adc_valid, o_frame_strobe, o_underrun});
      end
      if (o_adc !== '0) begin
         errors++; $display("FAIL reset_adc got=%h exp=0", o_adc);
      end
      if (o_dac_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready got=%b exp=1", o_dac_ready);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_clocks;
      apply_reset();
      clear_plan();
      checks++;
      if (o_dac_ready !== 1'b1) begin
         errors++; $display("FAIL clocks_ready got=%b exp=1", o_dac_ready);
      end
      run_plan(2, -1);
   endtask

   task automatic test_single_word;
      apply_reset();
      clear_plan();
      p_en[4]  = 1'b1;
      p_pos[4] = 7;
      p_dat[4] = {48'h0, 16'h8001};
      run_plan(7, -1);
   endtask

   task automatic test_loopback;
      apply_reset();
      clear_plan();
      p_en[2]  = 1'b1;
      p_pos[2] = 3;
      p_en[4]  = 1'b1;
      p_pos[4] = 20;
      p_dat[4] = {16'h1234, 16'hABCD, 16'h0001, 16'hFFFF};
      run_plan(8, -1);
      checks++;
      if (n_valid !== 8 - 1 - MUTE_FRAMES) begin
         errors++; $display("FAIL loopback_valid_count got=%0d exp=%0d", n_valid, 8 - 1 - MUTE_FRAMES);
      end
   endtask

   task automatic test_underrun;
      apply_reset();
      clear_plan();
      run_plan(8, -1);
      checks++;
      if (n_under !== 8 - 1 - MUTE_FRAMES) begin
         errors++; $display("FAIL underrun_count got=%0d exp=%0d", n_under, 8 - 1 - MUTE_FRAMES);
      end
   endtask

   task automatic test_offer_at_255;
      apply_reset();
      clear_plan();
      p_en[4]  = 1'b1;
      p_pos[4] = 100;
      p_en[5]  = 1'b1;
      p_pos[5] = FRAME - 1;
      run_plan(9, -1);
   endtask

   task automatic test_mid_reset;
      apply_reset();
      clear_plan();
      p_en[3]  = 1'b1;
      p_pos[3] = 10;
      p_en[5]  = 1'b1;
      p_pos[5] = 50;
      run_plan(6, 5 * FRAME + 100);
      checks++;
      if (o_dac_ready !== 1'b0) begin
         errors++; $display("FAIL midreset_hold_full got=%b exp=0", o_dac_ready);
      end
      rst_n = 1'b0;
      #1;
      checks += 3;
      if ({o_bick, o_lrck, o_sdin, o_adc_valid, o_frame_strobe, o_underrun} !== 6'b0) begin
         errors++;
         $display("FAIL midreset_pins got=%b exp=000000",
                  {o_bick, o_lrck, o_sdin, o_adc_valid, o_frame_strobe, o_underrun});
      end
      if (o_adc !== '0) begin
         errors++; $display("FAIL midreset_adc got=%h exp=0", o_adc);
      end
      if (o_dac_ready !== 1'b1) begin
         errors++; $display("FAIL midreset_ready got=%b exp=1", o_dac_ready);
      end
      repeat (3) @(posedge clk_256fs);
      #1;
      rst_n = 1'b1;
      checks++;
      if (o_dac_ready !== 1'b1) begin
         errors++; $display("FAIL midreset_ready_release got=%b exp=1", o_dac_ready);
      end
      clear_plan();
      p_en[4]  = 1'b1;
      p_pos[4] = 30;
      run_plan(7, -1);
   endtask

   task automatic test_random;
      for (int r = 0; r < 2; r++) begin
         apply_reset();
         clear_plan();
         for (int f = 0; f < 10; f++) begin
            p_en[f]  = ($urandom_range(0, 3) != 0);
            p_pos[f] = ($urandom_range(0, 5) == 0) ? FRAME - 1 : int'($urandom_range(0, FRAME - 2));
            if (f > 0 && p_en[f-1] && p_pos[f-1] == FRAME - 1) p_en[f] = 1'b0;
         end
         run_plan(10, -1);
      end
   endtask

   initial begin
      test_reset();
      test_clocks();
      test_single_word();
      test_loopback();
      test_underrun();
      test_offer_at_255();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
